parallel_shift_out: RTL

PARALLEL_SHIFT_OUT -- requirements
Module: parallel_shift_out

---
 rtl/parallel_shift_out.sv | 116 +++++++++++
 1 files changed

// File: rtl/parallel_shift_out.sv
// Parallel-in / serial-out word shifter: captures SIZE words of WIDTH bits and emits them MS word first.
// Optional macro PISO_AUTOLOAD_EN enables zero-bubble back-to-back block loading.
module parallel_shift_out #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [WIDTH*SIZE-1:0]    load_data,
    input  logic                     shift_signal,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid,
    output logic [$clog2(SIZE+1)-1:0] remaining,
    output logic                     done
);

    localparam int RW = $clog2(SIZE+1);
    localparam int TOP = WIDTH*SIZE-1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                  state_r;
    logic [WIDTH*SIZE-1:0]   buf_r;
    logic [WIDTH-1:0]        data_out_r;
    logic                    data_valid_r;
    logic                    done_r;
    logic [RW-1:0]           rem_r;

    logic                    load_ready_s;
    logic                    load_fire_s;
    logic                    shift_fire_s;

    // The autoload ready term looks at shift_signal so the next block can land on the same edge as the last shift.
`ifdef PISO_AUTOLOAD_EN
    assign load_ready_s = (state_r == IDLE) ||
                          ((state_r == SHIFT) && (rem_r == RW'(1)) && shift_signal);
`else
    assign load_ready_s = (state_r == IDLE);
`endif

    assign load_fire_s  = load_valid && load_ready_s;
    assign shift_fire_s = shift_signal && data_valid_r;

    // Main state machine: capture, shift out MS word first, pulse done after the last word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            buf_r        <= '0;
            data_out_r   <= {WIDTH{1'b0}};
            data_valid_r <= 1'b0;
            done_r       <= 1'b0;
            rem_r        <= {RW{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (load_fire_s) begin
                        buf_r        <= load_data << WIDTH;
                        data_out_r   <= load_data[TOP -: WIDTH];
                        data_valid_r <= 1'b1;
                        rem_r        <= RW'(SIZE);
                        state_r      <= SHIFT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    if (load_fire_s) begin
                        // Only reachable with autoload: last word consumed and next block captured together.
                        buf_r        <= load_data << WIDTH;
                        data_out_r   <= load_data[TOP -: WIDTH];
                        data_valid_r <= 1'b1;
                        rem_r        <= RW'(SIZE);
                        done_r       <= 1'b1;
                        state_r      <= SHIFT;
                    end else if (shift_fire_s) begin
                        if (rem_r == RW'(1)) begin
                            buf_r        <= '0;
                            data_out_r   <= {WIDTH{1'b0}};
                            data_valid_r <= 1'b0;
                            rem_r        <= {RW{1'b0}};
                            done_r       <= 1'b1;
                            state_r      <= IDLE;
                        end else begin
                            buf_r      <= buf_r << WIDTH;
                            data_out_r <= buf_r[TOP -: WIDTH];
                            rem_r      <= rem_r - RW'(1);
                            state_r    <= SHIFT;
                        end
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    buf_r        <= '0;
                    data_out_r   <= {WIDTH{1'b0}};
                    data_valid_r <= 1'b0;
                    rem_r        <= {RW{1'b0}};
                end
            endcase
        end
    end

    assign load_ready = load_ready_s;
    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign remaining  = rem_r;
    assign done       = done_r;

endmodule
